// File: rtl/pe_row_loader.sv
// ---------------------------------------------------------------------------
// pe_row_loader
//
// Feeder that sits between the tagged global-buffer distribution bus and a
// single processing element. Each instance serves one PE. The block:
//   - keeps bus words whose tag matches this PE's id or the all-ones
//     broadcast tag, and accepts and drops every other word;
//   - waits for the PE to raise pe_ready, then delivers exactly one row of
//     ROW_LEN words. Each word goes out as a one-cycle enable strobe plus a
//     data register on the ifmap or the filter channel;
//   - stalls matching words after a full row until the PE drops pe_ready
//     (it has started computing) and raises it again.
//
// Optional build feature (macro PE_ROW_LOADER_STATS_EN):
//   defined   -> extra 16-bit output drop_count. It counts accepted
//                non-matching words and saturates at 16'hFFFF.
//   undefined -> no drop_count port and no counter logic.
//
// Parameters:
//   BITWIDTH   data word width (PE datapath width)
//   ID_WIDTH   width of destination tag and local PE id
//   ROW_LEN    words per row delivered per ready window
//   CNT_WIDTH  row counter width, 2**CNT_WIDTH > ROW_LEN-1
//
// Ports:
//   clk               clock
//   rstb              asynchronous active-low reset
//   my_id             this PE's tag, static during operation
//   in_valid          bus word valid
//   in_ready          bus word accepted when in_valid & in_ready
//   in_data           bus word payload
//   in_is_filter      1 = filter word, 0 = ifmap word
//   in_tag            destination tag, all-ones = broadcast
//   pe_ready          PE ready flag
//   pe_ifmap_enable   one-cycle load strobe to PE ifmap RF
//   pe_filter_enable  one-cycle load strobe to PE filter RF
//   pe_ifmap          ifmap data to PE (holds last value)
//   pe_filter         filter data to PE (holds last value)
//   row_done          one-cycle pulse with the last word of a row
//   proto_err         sticky flag: row mixed ifmap and filter words
//   drop_count        (stats build only) saturating dropped-word count
// ---------------------------------------------------------------------------
module pe_row_loader #(
    parameter int BITWIDTH  = 16,
    parameter int ID_WIDTH  = 4,
    parameter int ROW_LEN   = 3,
    parameter int CNT_WIDTH = 2
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic [ID_WIDTH-1:0] my_id,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] in_data,
    input  logic                in_is_filter,
    input  logic [ID_WIDTH-1:0] in_tag,
    input  logic                pe_ready,
    output logic                pe_ifmap_enable,
    output logic                pe_filter_enable,
    output logic [BITWIDTH-1:0] pe_ifmap,
    output logic [BITWIDTH-1:0] pe_filter,
    output logic                row_done,
    output logic                proto_err
`ifdef PE_ROW_LOADER_STATS_EN
    ,
    output logic [15:0]         drop_count
`endif
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [1:0] ST_WAIT_READY = 2'd0;  // waiting for PE ready window
    localparam logic [1:0] ST_LOAD       = 2'd1;  // delivering a row
    localparam logic [1:0] ST_HOLD       = 2'd2;  // row done, waiting for PE to start

    localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(ROW_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [ID_WIDTH-1:0]  BCAST_TAG = '1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] count_nxt;
    logic                 row_is_filter;   // channel type latched from word 0

    // -----------------------------------------------------------------------
    // Bus-side decode
    // -----------------------------------------------------------------------
    logic match;
    logic accept;
    logic deliver;
    logic row_first;
    logic row_last;
    logic type_mismatch;

    // A broadcast tag is handled exactly like an exact id match.
    assign match = (in_tag == my_id) || (in_tag == BCAST_TAG);

    // Non-matching words are always sunk. Matching words pass only while a
    // row is being loaded, so HOLD and WAIT_READY back-pressure them.
    assign in_ready = !match || (state == ST_LOAD);

    assign accept  = in_valid && in_ready;
    assign deliver = accept && match;   // implies state == ST_LOAD

    assign row_first = (count == '0);
    assign row_last  = (count == LAST_IDX);

    // Only later words of a row can disagree with the latched row type.
    assign type_mismatch = deliver && !row_first && (in_is_filter != row_is_filter);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first, so every path assigns both signals and no
        // latch is inferred.
        state_nxt = state;
        count_nxt = count;
        case (state)
            ST_WAIT_READY: begin
                if (pe_ready) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // pe_ready is ignored here: once started, a row always completes.
                if (deliver) begin
                    if (row_last) begin
                        count_nxt = '0;
                        state_nxt = ST_HOLD;
                    end else begin
                        count_nxt = count + CNT_ONE;
                    end
                end
            end
            ST_HOLD: begin
                // The PE drops pe_ready when it begins computing on the row.
                if (!pe_ready) begin
                    state_nxt = ST_WAIT_READY;
                end
            end
            default: begin
                state_nxt = ST_WAIT_READY;
                count_nxt = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every flop samples the pre-edge values of its inputs.
            state         <= ST_WAIT_READY;
            count         <= '0;
            row_is_filter <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (deliver && row_first) begin
                row_is_filter <= in_is_filter;
            end
        end
    end

    // -----------------------------------------------------------------------
    // PE-side output registers: one cycle latency from acceptance
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            // NOTE: the data registers are reset as well. They are single
            // flops, not a memory array, and the PE must see zero after reset.
            pe_ifmap_enable  <= 1'b0;
            pe_filter_enable <= 1'b0;
            pe_ifmap         <= '0;
            pe_filter        <= '0;
            row_done         <= 1'b0;
            proto_err        <= 1'b0;
        end else begin
            // Strobes are recomputed every cycle, so each is high for exactly
            // one cycle per delivered word.
            pe_ifmap_enable  <= deliver && !in_is_filter;
            pe_filter_enable <= deliver &&  in_is_filter;
            row_done         <= deliver && row_last;

            // Only the selected channel's data register loads. The other
            // channel keeps its last value.
            if (deliver && !in_is_filter) begin
                pe_ifmap <= in_data;
            end
            if (deliver && in_is_filter) begin
                pe_filter <= in_data;
            end

            // A mismatched word is still forwarded and counted. It only
            // raises the sticky error flag.
            if (type_mismatch) begin
                proto_err <= 1'b1;
            end
        end
    end

`ifdef PE_ROW_LOADER_STATS_EN
    // -----------------------------------------------------------------------
    // Saturating count of dropped (accepted, non-matching) words
    // -----------------------------------------------------------------------
    logic drop;
    assign drop = accept && !match;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            drop_count <= 16'd0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_row_loader.sv
// ---------------------------------------------------------------------------
// tb_pe_row_loader
//
// Self-checking bench for pe_row_loader using a scoreboard.
//
// The driver applies one bus cycle at a time, on the falling edge, and
// checks in_ready against a reference model. That model works on rows:
//   - a ready window opens after pe_ready is seen;
//   - a window holds ROW_LEN words;
//   - a full row waits for pe_ready to drop.
// Each delivered word pushes its expected PE-side effect into a queue:
//   - the due cycle;
//   - the channel and the data;
//   - whether it ends the row;
//   - whether it breaks the row type.
// A separate monitor samples one time unit after each rising edge. It pops
// and compares whenever an enable strobe appears. It also checks the held
// data registers and proto_err every cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pe_row_loader;

    localparam int BW      = 16;
    localparam int IW      = 4;
    localparam int ROW_LEN = 3;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic [IW-1:0] my_id = 4'd2;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_data = '0;
    logic          in_is_filter = 1'b0;
    logic [IW-1:0] in_tag = '0;
    logic          pe_ready = 1'b0;
    logic          pe_ifmap_enable;
    logic          pe_filter_enable;
    logic [BW-1:0] pe_ifmap;
    logic [BW-1:0] pe_filter;
    logic          row_done;
    logic          proto_err;
`ifdef PE_ROW_LOADER_STATS_EN
    logic [15:0]   drop_count;
`endif

    pe_row_loader #(
        .BITWIDTH (BW),
        .ID_WIDTH (IW),
        .ROW_LEN  (ROW_LEN),
        .CNT_WIDTH(2)
    ) dut (
        .clk             (clk),
        .rstb            (rstb),
        .my_id           (my_id),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_is_filter    (in_is_filter),
        .in_tag          (in_tag),
        .pe_ready        (pe_ready),
        .pe_ifmap_enable (pe_ifmap_enable),
        .pe_filter_enable(pe_filter_enable),
        .pe_ifmap        (pe_ifmap),
        .pe_filter       (pe_filter),
        .row_done        (row_done),
        .proto_err       (proto_err)
`ifdef PE_ROW_LOADER_STATS_EN
        ,
        .drop_count      (drop_count)
`endif
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef enum {W_IDLE, W_OPEN, W_FULL} window_t;

    typedef struct {
        int          due;
        bit          f;
        logic [15:0] d;
        bit          last;
        bit          mis;
    } exp_t;

    exp_t    sb[$];        // expected PE-side events, oldest first
    window_t win = W_IDLE; // where the PE's ready window stands
    bit      row_f[$];     // channel types of words delivered in current row
    int      exp_drop = 0;

    function automatic bit is_match(input logic [IW-1:0] tag);
        return (tag == my_id) || (tag == 4'hF);
    endfunction

    // One bus cycle: drive on the falling edge, check in_ready, record the
    // expected effect, then advance the model across the rising edge.
    task automatic drive_cycle(input bit v, input logic [IW-1:0] tag, input logic [15:0] d,
                               input bit f, input bit pr, output bit acc);
        bit   m;
        bit   exp_rdy;
        exp_t e;
        @(negedge clk);
        in_valid     = v;
        in_tag       = tag;
        in_data      = d;
        in_is_filter = f;
        pe_ready     = pr;
        #1;
        m       = is_match(tag);
        exp_rdy = !m || (win == W_OPEN);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
`ifdef PE_ROW_LOADER_STATS_EN
        check("drop_count", 32'(drop_count), 32'(exp_drop));
`endif
        acc = v && exp_rdy;
        e.last = 1'b0;
        if (acc && m) begin
            e.due  = cyc + 1;
            e.f    = f;
            e.d    = d;
            e.mis  = (row_f.size() > 0) && (f != row_f[0]);
            row_f.push_back(f);
            e.last = (row_f.size() == ROW_LEN);
            sb.push_back(e);
        end
        @(posedge clk);
        if (acc && m && e.last) begin
            win = W_FULL;
            row_f.delete();
        end else if (win == W_FULL && !pr) begin
            win = W_IDLE;
        end else if (win == W_IDLE && pr) begin
            win = W_OPEN;
        end
        if (acc && !m && exp_drop < 65535) exp_drop++;
    endtask

    // Offer one word with pe_ready held high until it is accepted.
    task automatic send_word(input logic [IW-1:0] tag, input logic [15:0] d, input bit f);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            drive_cycle(1'b1, tag, d, f, 1'b1, acc);
        end
        if (!acc) check("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle_cycle(input bit pr);
        bit acc;
        drive_cycle(1'b0, my_id, 16'h0, 1'b0, pr, acc);
    endtask

    // A full row is followed by one cycle with pe_ready low, so the next row
    // starts from a fresh ready window.
    task automatic close_window();
        idle_cycle(1'b0);
    endtask

    // Reset with pe_ready low, so the cycle around release changes nothing.
    task automatic do_reset(input logic [IW-1:0] new_id);
        @(negedge clk);
        in_valid = 1'b0;
        pe_ready = 1'b0;
        rstb     = 1'b0;
        #1;
        check("rst_ifmap_en",  32'(pe_ifmap_enable),  32'd0);
        check("rst_filter_en", 32'(pe_filter_enable), 32'd0);
        check("rst_ifmap",     32'(pe_ifmap),         32'd0);
        check("rst_filter",    32'(pe_filter),        32'd0);
        check("rst_row_done",  32'(row_done),         32'd0);
        check("rst_proto_err", 32'(proto_err),        32'd0);
        my_id  = new_id;
        in_tag = new_id;
        #1;
        check("rst_in_ready_match", 32'(in_ready), 32'd0);
        win = W_IDLE;
        row_f.delete();
        exp_drop = 0;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [15:0] e_if = '0;
    logic [15:0] e_fl = '0;
    bit          e_proto = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rstb) begin
                sb.delete();
                e_if    = '0;
                e_fl    = '0;
                e_proto = 1'b0;
            end else if (pe_ifmap_enable || pe_filter_enable) begin
                check("enable_onehot", 32'(pe_ifmap_enable & pe_filter_enable), 32'd0);
                if (sb.size() == 0) begin
                    check("spurious_enable", 32'({pe_ifmap_enable, pe_filter_enable}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("latency", 32'(cyc), 32'(e.due));
                    check("channel", 32'(pe_filter_enable), 32'(e.f));
                    check("row_done", 32'(row_done), 32'(e.last));
                    if (e.f) e_fl = e.d;
                    else     e_if = e.d;
                    if (e.mis) e_proto = 1'b1;
                end
            end else begin
                check("row_done_idle", 32'(row_done), 32'd0);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    check("missing_enable", 32'(pe_ifmap_enable | pe_filter_enable), 32'd1);
                    void'(sb.pop_front());
                end
            end
            check("pe_ifmap",  32'(pe_ifmap),  32'(e_if));
            check("pe_filter", 32'(pe_filter), 32'(e_fl));
            check("proto_err", 32'(proto_err), 32'(e_proto));
        end
    end

    // Watchdog: the run must always end on its own.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit              acc;
        bit              pr;
        bit              cur_type;
        logic [IW-1:0]   tag;
        int              r;

        // Reset, released with pe_ready low: matching words stalled.
        do_reset(4'd2);
        repeat (3) drive_cycle(1'b1, 4'd2, 16'h0055, 1'b0, 1'b0, acc);

        // pe_ready rises: three ifmap words 5, -3, 7 back-to-back.
        send_word(4'd2, 16'd5,    1'b0);
        send_word(4'd2, 16'hFFFD, 1'b0);
        send_word(4'd2, 16'd7,    1'b0);

        // Row full: matching words stall while pe_ready stays high.
        repeat (3) drive_cycle(1'b1, 4'd2, 16'h0077, 1'b0, 1'b1, acc);

        // Words for another PE are sunk with no enable, even while holding.
        repeat (4) drive_cycle(1'b1, 4'd4, 16'h0BAD, 1'b0, 1'b1, acc);
        close_window();

        // Broadcast filter row 1, 2, 3.
        send_word(4'hF, 16'd1, 1'b1);
        send_word(4'hF, 16'd2, 1'b1);
        send_word(4'hF, 16'd3, 1'b1);
        close_window();

        // Mixed-type row: ifmap 9, filter 8, ifmap 6 -> sticky proto_err.
        send_word(4'd2, 16'd9, 1'b0);
        send_word(4'd2, 16'd8, 1'b1);
        send_word(4'd2, 16'd6, 1'b0);
        repeat (3) idle_cycle(1'b1);
        close_window();

        // Reset after two words of a row, then a fresh full row.
        send_word(4'd2, 16'd11, 1'b0);
        send_word(4'd2, 16'd12, 1'b0);
        do_reset(4'd2);
        send_word(4'd2, 16'd21, 1'b0);
        send_word(4'd2, 16'd22, 1'b0);
        send_word(4'd2, 16'd23, 1'b0);
        close_window();

        // Randomized traffic.
        pr       = 1'b0;
        cur_type = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) begin
                do_reset(4'd9);
                pr = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) pr = !pr;
            if ($urandom_range(0, 7) == 0) cur_type = !cur_type;
            r = $urandom_range(0, 99);
            if (r < 50)      tag = my_id;
            else if (r < 65) tag = 4'hF;
            else begin
                do tag = 4'($urandom_range(0, 14)); while (tag == my_id);
            end
            drive_cycle($urandom_range(0, 3) != 0, tag, 16'($urandom),
                        ($urandom_range(0, 9) == 0) ? !cur_type : cur_type, pr, acc);
        end

        // Drain.
        repeat (4) idle_cycle(1'b0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
